keypad_entry_decoder: RTL and testbench
=======================================

Name: keypad_entry_decoder

Overview:
- Input-side counterpart of the alarm-clock LCD driver. That driver encodes BCD digits to LCD ASCII codes; this block decodes ASCII key codes from the keypad back to BCD.
- Debounces each key press, decodes codes 8'h30–8'h39 to 4-bit digits and shifts them into a 4-digit entry buffer.
- Supplies `key`, the entry buffer and the `show_new_time` status to the display and time-load logic.
- Abandons a stale entry after a timeout.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples needed to accept a press or a release (minimum 2).
- TIMEOUT_CYCLES, 100, idle cycles after the last accepted digit before the entry is cleared (minimum 2).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- key_code  in  8  ASCII code from the keypad. It is stable for the whole time key_down is high.
- key_down  in  1  asynchronous level, high while a key is held. It may bounce.
- clear_entry  in  1  synchronous request to clear the buffer, e.g. after a time or alarm load.
- key  out  4  last accepted digit; feeds the LCD driver `key` input.
- key_buffer  out  16  four entered digits: [15:12] oldest, [3:0] newest.
- key_valid  out  1  one-cycle pulse when a digit is shifted in.
- key_error  out  1  one-cycle pulse when an accepted press carries a non-digit code.
- entry_active  out  1  high from the first digit until timeout or clear; drives the LCD driver `show_new_time` input.

Behaviour:
- **Reset (reset_n low, async):** key=0, key_buffer=0, key_valid=0, key_error=0, entry_active=0, FSM=IDLE, all counters 0, synchronizer flops 0.
- **Synchronizer:** key_down passes through 2 flops to give k_s. key_code is not synchronized; it is sampled on the accept edge.
- **FSM states:** IDLE, DEBOUNCE, HELD, RELEASE. One shared counter, cnt.
  - IDLE: k_s=1 → DEBOUNCE with cnt=1.
  - DEBOUNCE: k_s=0 → IDLE with cnt=0. k_s=1 and cnt==DEBOUNCE_CYCLES-1 → ACCEPT, then HELD. Otherwise cnt++.
  - HELD: k_s=0 → RELEASE with cnt=1. No repeat while held.
  - RELEASE: k_s=1 → HELD. k_s=0 and cnt==DEBOUNCE_CYCLES-1 → IDLE. Otherwise cnt++.
- **Accept latency:** key_valid is high in the cycle after edge N0+DEBOUNCE_CYCLES+1, where N0 is the first edge that samples key_down=1.
- **Glitch rejection:** key_down high for fewer than DEBOUNCE_CYCLES sampling edges produces no output.
- **ACCEPT with a digit code (8'h30..8'h39):**
  - key <= key_code[3:0]
  - key_buffer <= {key_buffer[11:0], key_code[3:0]}
  - key_valid pulses for one cycle
  - entry_active <= 1
  - timeout counter <= 0
- **ACCEPT with any other code:** key_error pulses for one cycle; key, key_buffer, entry_active and the timer are unchanged.
- **Buffer overflow:** more than 4 digits shifts the oldest digit out. There is no error for this.
- **Timeout:** while entry_active=1 and there is no accept, the timer increments every cycle. When the timer reaches TIMEOUT_CYCLES-1, the next edge sets key_buffer=0, key=0, entry_active=0 and timer=0. An in-progress press in the FSM is not affected.
- **clear_entry=1:** the next edge sets key_buffer=0, key=0, entry_active=0 and timer=0.
- **Simultaneous events:**
  - clear_entry and ACCEPT of a digit in the same cycle: clear first, then shift. Result: key_buffer={12'h000,digit}, key_valid=1, entry_active=1.
  - ACCEPT and timeout expiry in the same cycle: ACCEPT wins. The digit shifts into the existing buffer and the timer resets.
  - clear_entry and timeout in the same cycle: identical result.
- **Reset mid-press:** everything returns to reset values. A key still held after reset release is accepted as a new press once debounced.
- **Width rules:** cnt is wide enough to hold DEBOUNCE_CYCLES-1. The timer is wide enough to hold TIMEOUT_CYCLES-1. Neither counter wraps; each is held or cleared by the FSM and timeout rules.

Decomposition:
- Shared package alarm_clock_pkg holds:
  - LCD/ASCII digit constants ZERO..NINE (8'h30..8'h39) and ERROR (8'h3A), common with the LCD driver;
  - the FSM state encoding;
  - the BCD digit width (4).
- One natural sub-module: sync_2ff, a 2-flop synchronizer for key_down with async active-low reset.

Test Plan (all with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100):
- Reset mid-press: assert reset_n=0 asynchronously → all outputs 0 immediately. Release reset with the key still held → accepted as a fresh press after debounce.
- Clean press: key_code=8'h37, key_down high 10 cycles → one key_valid pulse at edge N0+5; key=4'h7; key_buffer=16'h0007; entry_active=1; no second pulse while held.
- Glitch rejection: key_down high 3 cycles, then low, then a bouncy release (0/1/0 within 3 cycles) → no key_valid, no key_error, and exactly one accept overall for a surrounding real press.
- Entry sequence: digits 1,2,3,0,5 as separate clean presses → key_buffer=16'h1230 after the fourth, 16'h2305 after the fifth; exactly 5 key_valid pulses.
- Error and timeout:
  - key_code=8'h2A ('*') press → key_error pulse; buffer unchanged.
  - Then 100 idle cycles after the last digit → key_buffer=0, key=0, entry_active=0.
  - Accept landing on the expiry cycle → buffer retained plus the new digit.
- Clear collision: clear_entry asserted on the accept edge of digit 9 with buffer=16'h1234 → key_buffer=16'h0009, key_valid=1, entry_active=1.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock definitions: LCD/ASCII digit codes, keypad FSM state
// encoding and the BCD digit width.
package alarm_clock_pkg;

   localparam int unsigned DIGIT_W = 4;

   // ASCII codes shared with the LCD driver
   localparam logic [7:0] ZERO  = 8'h30;
   localparam logic [7:0] ONE   = 8'h31;
   localparam logic [7:0] TWO   = 8'h32;
   localparam logic [7:0] THREE = 8'h33;
   localparam logic [7:0] FOUR  = 8'h34;
   localparam logic [7:0] FIVE  = 8'h35;
   localparam logic [7:0] SIX   = 8'h36;
   localparam logic [7:0] SEVEN = 8'h37;
   localparam logic [7:0] EIGHT = 8'h38;
   localparam logic [7:0] NINE  = 8'h39;
   localparam logic [7:0] ERROR = 8'h3A;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } kp_state_e;

   // True for the ASCII codes '0'..'9'
   function automatic logic is_digit(input logic [7:0] code);
      return (code >= ZERO) && (code <= NINE);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (flops clear to 0)
//   d_i    : asynchronous input level
//   q_o    : synchronized level, two clock edges of latency
module sync_2ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_entry_decoder.sv
// Keypad entry decoder: debounces key presses, decodes ASCII '0'..'9' to BCD
// and shifts digits into a 4-digit entry buffer that is abandoned on timeout.
//   clock        : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   key_code     : ASCII code from the keypad, stable while key_down is high
//   key_down     : asynchronous, possibly bouncing, key-held level
//   clear_entry  : synchronous request to clear the entry buffer
//   key          : last accepted digit
//   key_buffer   : four entered digits, [15:12] oldest, [3:0] newest
//   key_valid    : one-cycle pulse when a digit is shifted in
//   key_error    : one-cycle pulse when an accepted press is not a digit
//   entry_active : high from the first digit until timeout or clear
module keypad_entry_decoder
   import alarm_clock_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 100
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [7:0]   key_code,
   input  logic         key_down,
   input  logic         clear_entry,
   output logic [3:0]   key,
   output logic [15:0]  key_buffer,
   output logic         key_valid,
   output logic         key_error,
   output logic         entry_active
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned BUF_W = 4 * DIGIT_W;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic               k_s;
   kp_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               accept_c;

   logic [DIGIT_W-1:0] key_q, key_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic               valid_q, valid_d;
   logic               error_q, error_d;
   logic               active_q, active_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;

   logic               code_is_digit;
   logic [DIGIT_W-1:0] code_digit;

   sync_2ff u_sync_key_down (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .d_i    (key_down),
      .q_o    (k_s)
   );

   assign code_is_digit = is_digit(key_code);
   assign code_digit    = key_code[DIGIT_W-1:0];

   // Debounce FSM state and shared counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Debounce next-state: a press or release must be stable DEBOUNCE_CYCLES samples
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (k_s) begin
               state_d = ST_DEBOUNCE;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_DEBOUNCE: begin
            if (!k_s) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d  = ST_HELD;
               cnt_d    = '0;
               accept_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_HELD: begin
            if (!k_s) begin
               state_d = ST_RELEASE;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            // A bounce back high returns to HELD without a new accept
            if (k_s) begin
               state_d = ST_HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Entry buffer, outputs and inactivity timer
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         key_q    <= '0;
         buf_q    <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         active_q <= 1'b0;
         tmr_q    <= '0;
      end else begin
         key_q    <= key_d;
         buf_q    <= buf_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
         active_q <= active_d;
         tmr_q    <= tmr_d;
      end
   end

   // Clear/timeout are applied first so a same-cycle digit lands in the cleared
   // buffer; any accept (digit or not) suppresses the timeout for that cycle.
   always_comb begin
      key_d    = key_q;
      buf_d    = buf_q;
      active_d = active_q;
      tmr_d    = tmr_q;
      valid_d  = 1'b0;
      error_d  = 1'b0;

      if (clear_entry) begin
         key_d    = '0;
         buf_d    = '0;
         active_d = 1'b0;
         tmr_d    = '0;
      end else if (active_q && !accept_c) begin
         if (tmr_q == TMR_LAST) begin
            key_d    = '0;
            buf_d    = '0;
            active_d = 1'b0;
            tmr_d    = '0;
         end else begin
            tmr_d = tmr_q + TMR_W'(1);
         end
      end

      if (accept_c) begin
         if (code_is_digit) begin
            key_d    = code_digit;
            buf_d    = {buf_d[BUF_W-DIGIT_W-1:0], code_digit};
            valid_d  = 1'b1;
            active_d = 1'b1;
            tmr_d    = '0;
         end else begin
            error_d = 1'b1;
         end
      end
   end

   assign key          = key_q;
   assign key_buffer   = buf_q;
   assign key_valid    = valid_q;
   assign key_error    = error_q;
   assign entry_active = active_q;

endmodule

// File: tb/tb_keypad_entry_decoder.sv
// Self-checking bench for keypad_entry_decoder: scoreboard of expected accepts
// filled by the stimulus, drained by a monitor watching key_valid/key_error.
module tb_keypad_entry_decoder;

   localparam int D = 4;
   localparam int T = 100;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  key_code = 8'h00;
   logic        key_down = 1'b0;
   logic        clear_entry = 1'b0;
   logic [3:0]  key;
   logic [15:0] key_buffer;
   logic        key_valid;
   logic        key_error;
   logic        entry_active;

   keypad_entry_decoder #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .key_code     (key_code),
      .key_down     (key_down),
      .clear_entry  (clear_entry),
      .key          (key),
      .key_buffer   (key_buffer),
      .key_valid    (key_valid),
      .key_error    (key_error),
      .entry_active (entry_active)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         at;
      bit         err;
      logic [3:0] k;
      logic [15:0] bv;
      bit         act;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int n_valid = 0;
   int n_error = 0;

   // Reference model of the entry: digits as a plain list of the last four
   logic [15:0] m_buf = '0;
   logic [3:0]  m_key = '0;
   bit          m_active = 0;
   int          m_expire = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic m_zero();
      m_buf = '0;
      m_key = '0;
      m_active = 0;
   endtask

   // Apply a timeout that has already happened by edge t
   task automatic m_sync(input int t);
      if (m_active && m_expire <= t) m_zero();
   endtask

   // Predict the effect of an accepted press at edge a
   task automatic m_accept(input logic [7:0] code, input int a, input bit clr);
      exp_t e;
      m_sync(a - 1);
      if (clr) m_zero();
      if (code >= 8'h30 && code <= 8'h39) begin
         m_buf = {m_buf[11:0], code[3:0]};
         m_key = code[3:0];
         m_active = 1;
         m_expire = a + T;
         e.err = 0;
      end else begin
         if (m_active) m_expire = m_expire + 1;
         e.err = 1;
      end
      e.at = a;
      e.k = m_key;
      e.bv = m_buf;
      e.act = m_active;
      q.push_back(e);
   endtask

   task automatic chk_state(input string nm);
      m_sync(cyc);
      chk({nm, "_buf"}, 32'(key_buffer), 32'(m_buf));
      chk({nm, "_key"}, 32'(key), 32'(m_key));
      chk({nm, "_act"}, 32'(entry_active), 32'(m_active));
   endtask

   // Clean press: key held `hold` cycles then low for `gap`; optional clear on the accept edge
   task automatic press(input logic [7:0] code, input int hold, input int gap, input bit clr);
      int k;
      k = cyc;
      key_code = code;
      key_down = 1'b1;
      if (hold >= D) m_accept(code, k + D + 2, clr);
      for (int n = 1; n <= hold + gap; n++) begin
         @(negedge clock);
         if (n == hold) key_down = 1'b0;
         if (clr && n == D + 1) clear_entry = 1'b1;
         if (clr && n == D + 2) clear_entry = 1'b0;
      end
   endtask

   task automatic pulse_clear();
      clear_entry = 1'b1;
      @(negedge clock);
      clear_entry = 1'b0;
      m_zero();
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clock);
   endtask

   // Monitor: every output pulse must match the head of the scoreboard
   always @(negedge clock) begin
      if (reset_n && (key_valid || key_error)) begin
         if (key_valid) n_valid++;
         if (key_error) n_error++;
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got valid=%0b error=%0b expected none (cycle %0d)",
                     key_valid, key_error, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("acc_cycle", 32'(cyc), 32'(e.at));
            chk("acc_error", 32'(key_error), 32'(e.err));
            chk("acc_valid", 32'(key_valid), 32'(!e.err));
            chk("acc_key", 32'(key), 32'(e.k));
            chk("acc_buf", 32'(key_buffer), 32'(e.bv));
            chk("acc_act", 32'(entry_active), 32'(e.act));
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int e0;
      int k;
      logic [7:0] code;
      logic [7:0] bad_codes [5];
      bad_codes[0] = 8'h2A; bad_codes[1] = 8'h23; bad_codes[2] = 8'h3A;
      bad_codes[3] = 8'h41; bad_codes[4] = 8'h00;

      // Reset state
      repeat (3) @(negedge clock);
      chk("rst_key", 32'(key), 32'h0);
      chk("rst_buf", 32'(key_buffer), 32'h0);
      chk("rst_valid", 32'(key_valid), 32'h0);
      chk("rst_error", 32'(key_error), 32'h0);
      chk("rst_act", 32'(entry_active), 32'h0);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Clean press of '7', held 10 cycles
      n0 = n_valid;
      press(8'h37, 10, 12, 0);
      chk("clean_buf", 32'(key_buffer), 32'h0007);
      chk("clean_key", 32'(key), 32'h7);
      chk("clean_act", 32'(entry_active), 32'h1);
      chk("clean_pulses", 32'(n_valid - n0), 32'd1);

      // Reset mid-press, then key still held after release of reset
      key_code = 8'h33;
      key_down = 1'b1;
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_key", 32'(key), 32'h0);
      chk("midrst_buf", 32'(key_buffer), 32'h0);
      chk("midrst_act", 32'(entry_active), 32'h0);
      m_zero();
      @(negedge clock);
      reset_n = 1'b1;
      k = cyc;
      m_accept(8'h33, k + D + 2, 0);
      repeat (8) @(negedge clock);
      key_down = 1'b0;
      repeat (10) @(negedge clock);
      chk("midrst_after_buf", 32'(key_buffer), 32'h0003);
      chk_state("midrst_after");

      // Glitch rejection then a real press with a bouncy release
      n0 = n_valid;
      e0 = n_error;
      press(8'h35, 3, 10, 0);
      chk("glitch_valid", 32'(n_valid - n0), 32'd0);
      chk("glitch_error", 32'(n_error - e0), 32'd0);
      k = cyc;
      key_code = 8'h38;
      key_down = 1'b1;
      m_accept(8'h38, k + D + 2, 0);
      repeat (10) @(negedge clock);
      key_down = 1'b0;
      @(negedge clock);
      key_down = 1'b1;
      @(negedge clock);
      key_down = 1'b0;
      repeat (12) @(negedge clock);
      chk("bounce_pulses", 32'(n_valid - n0), 32'd1);

      // Entry sequence 1,2,3,0,5
      pulse_clear();
      chk("clear_buf", 32'(key_buffer), 32'h0);
      n0 = n_valid;
      press(8'h31, 6, 10, 0);
      press(8'h32, 5, 9, 0);
      press(8'h33, 7, 10, 0);
      press(8'h30, 4, 8, 0);
      chk("seq4_buf", 32'(key_buffer), 32'h1230);
      press(8'h35, 6, 10, 0);
      chk("seq5_buf", 32'(key_buffer), 32'h2305);
      chk("seq_pulses", 32'(n_valid - n0), 32'd5);

      // Non-digit press: error pulse, buffer unchanged
      press(8'h2A, 6, 10, 0);
      chk("err_buf", 32'(key_buffer), 32'h2305);

      // Timeout boundary
      wait_until(m_expire - 1);
      chk_state("pre_expiry");
      chk("pre_expiry_act_c", 32'(entry_active), 32'h1);
      @(negedge clock);
      chk_state("expiry");
      chk("expiry_buf_c", 32'(key_buffer), 32'h0);
      chk("expiry_key_c", 32'(key), 32'h0);
      chk("expiry_act_c", 32'(entry_active), 32'h0);

      // Accept landing exactly on the expiry edge keeps the buffer
      repeat (3) @(negedge clock);
      press(8'h34, 5, 10, 0);
      wait_until(m_expire - D - 2);
      press(8'h36, 5, 10, 0);
      chk("land_buf", 32'(key_buffer), 32'h0046);
      chk("land_act", 32'(entry_active), 32'h1);

      // Clear on the accept edge of '9'
      pulse_clear();
      press(8'h31, 5, 8, 0);
      press(8'h32, 5, 8, 0);
      press(8'h33, 5, 8, 0);
      press(8'h34, 5, 8, 0);
      chk("pre_clr_buf", 32'(key_buffer), 32'h1234);
      press(8'h39, 6, 10, 1);
      chk("clr_col_buf", 32'(key_buffer), 32'h0009);
      chk("clr_col_act", 32'(entry_active), 32'h1);

      // Randomized presses, glitches, gaps, clears and expiry landings
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0) code = 8'h30 + 8'($urandom_range(0, 9));
         else code = bad_codes[$urandom_range(0, 4)];
         if ($urandom_range(0, 4) == 0 && m_active && (m_expire - D - 2 > cyc))
            wait_until(m_expire - D - 2);
         press(code, $urandom_range(1, 12), $urandom_range(8, 130), 0);
         chk_state("rand");
         if ($urandom_range(0, 7) == 0) begin
            pulse_clear();
            @(negedge clock);
            chk_state("rand_clr");
         end
      end

      repeat (10) @(negedge clock);
      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
